// File: rtl/hash_table_pipeline_if.sv
// Stream handshake bundle for hash_table_pipeline: request beat in
// (data/valid/last/keep, ready back) and result beat out (valid/data/last/keep, ready in).
interface hash_table_pipeline_if #(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  valid_i;
  logic                  ready_o;
  logic                  last_i;
  logic [KEEP_WIDTH-1:0] keep_i;
  logic                  ready_i;
  logic                  valid_o;
  logic [DATA_WIDTH-1:0] read_data_o;
  logic                  last_o;
  logic [KEEP_WIDTH-1:0] keep_o;

  modport master (
    output data_in, valid_i, last_i, keep_i, ready_i,
    input  ready_o, valid_o, read_data_o, last_o, keep_o
  );

  modport slave (
    input  data_in, valid_i, last_i, keep_i, ready_i,
    output ready_o, valid_o, read_data_o, last_o, keep_o
  );
endinterface

// File: rtl/hash_table_pipeline.sv
// Direct-mapped key/value table on a valid/ready stream; ports: clk, reset (async low),
// bus (slave), fill_count_o; optional hit/miss/collision counters via HASH_TABLE_PIPELINE_STATS_EN.
module hash_table_pipeline #(
  parameter int DATA_WIDTH  = 32,
  parameter int KEY_WIDTH   = 12,
  parameter int VALUE_WIDTH = 16,
  parameter int ADDR_WIDTH  = 4,
  parameter int KEEP_WIDTH  = 8,
  parameter int OUT_STAGES  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  hash_table_pipeline_if.slave  bus,
  output logic [ADDR_WIDTH:0]   fill_count_o
`ifdef HASH_TABLE_PIPELINE_STATS_EN
  ,
  output logic [31:0]           hit_count_o,
  output logic [31:0]           miss_count_o,
  output logic [31:0]           collision_count_o
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int NS    = OUT_STAGES + 1;
  localparam int NSL   = (KEY_WIDTH + ADDR_WIDTH - 1) / ADDR_WIDTH;
  localparam int KO    = VALUE_WIDTH;
  localparam int PAD   = DATA_WIDTH - KEY_WIDTH - VALUE_WIDTH;

  localparam logic [DATA_WIDTH-1:0] KV_MASK =
    {{PAD{1'b0}}, {(KEY_WIDTH + VALUE_WIDTH){1'b1}}};

  localparam logic [1:0] ST_NOP  = 2'b00;
  localparam logic [1:0] ST_HIT  = 2'b01;
  localparam logic [1:0] ST_MISS = 2'b10;
  localparam logic [1:0] ST_COL  = 2'b11;

  function automatic logic [ADDR_WIDTH-1:0] fold(
    input logic [KEY_WIDTH-1:0] k
  );
    logic [NSL*ADDR_WIDTH-1:0] p;
    p = '0;
    p[KEY_WIDTH-1:0] = k;
    fold = '0;
    for (int i = 0; i < NSL; i++)
      fold ^= p[i*ADDR_WIDTH +: ADDR_WIDTH];
  endfunction

  logic                   v1;
  logic [DATA_WIDTH-1:0]  d1;
  logic                   l1;
  logic [KEEP_WIDTH-1:0]  k1;
  logic [ADDR_WIDTH-1:0]  i1;

  logic [NS-1:0]          sv;
  logic [DATA_WIDTH-1:0]  sd [NS];
  logic [NS-1:0]          sl;
  logic [KEEP_WIDTH-1:0]  sk [NS];

  logic [NS-1:0]          en_s;
  logic                   en1;

  logic [DEPTH-1:0]       occ;
  logic [KEY_WIDTH-1:0]   tkey [DEPTH];
  logic [VALUE_WIDTH-1:0] tval [DEPTH];
  logic [ADDR_WIDTH:0]    fill;

  logic [1:0]             op1;
  logic [KEY_WIDTH-1:0]   key1;
  logic [VALUE_WIDTH-1:0] val1;
  logic                   hit;
  logic [1:0]             st;
  logic [DATA_WIDTH-1:0]  res;
  logic                   wr;
  logic                   set;
  logic                   clr;
  logic                   xfer;

  assign op1  = d1[DATA_WIDTH-1 -: 2];
  assign key1 = d1[KO +: KEY_WIDTH];
  assign val1 = d1[VALUE_WIDTH-1:0];

  // A stage may load when empty or when everything after it moves;
  // folded as "ready_i or some stage from here down is a bubble".
  always_comb begin
    logic all_v;
    all_v = 1'b1;
    en_s  = '0;
    for (int i = NS - 1; i >= 0; i--) begin
      all_v   = all_v & sv[i];
      en_s[i] = bus.ready_i | ~all_v;
    end
    en1 = bus.ready_i | ~(all_v & v1);
  end

  assign bus.ready_o = en1;
  assign xfer        = v1 & en_s[0];

  always_comb begin
    hit = occ[i1] && (tkey[i1] == key1);
    res = d1 & KV_MASK;
    st  = ST_NOP;
    wr  = 1'b0;
    set = 1'b0;
    clr = 1'b0;
    unique case (1'b1)
      op1 == 2'b01: begin
        if (hit) begin
          st = ST_HIT;
          res[VALUE_WIDTH-1:0] = tval[i1];
        end else begin
          st = ST_MISS;
        end
      end
      op1 == 2'b10: begin
        if (!occ[i1]) begin
          st  = ST_HIT;
          wr  = 1'b1;
          set = 1'b1;
        end else if (hit) begin
          st = ST_HIT;
          wr = 1'b1;
        end else begin
          st = ST_COL;
        end
      end
      op1 == 2'b11: begin
        if (hit) begin
          st  = ST_HIT;
          clr = 1'b1;
        end else begin
          st = ST_MISS;
        end
      end
      default: st = ST_NOP;
    endcase
    res[DATA_WIDTH-1 -: 2] = st;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ  <= '0;
      fill <= '0;
    end else if (xfer) begin
      if (set) begin
        occ[i1] <= 1'b1;
        fill    <= fill + 1'b1;
      end
      if (clr) begin
        occ[i1] <= 1'b0;
        fill    <= fill - 1'b1;
      end
    end
  end

  // Key/value payload needs no reset: occ gates every use.
  always_ff @(posedge clk) begin
    if (xfer && wr) begin
      tkey[i1] <= key1;
      tval[i1] <= val1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1 <= 1'b0;
      d1 <= '0;
      l1 <= 1'b0;
      k1 <= '0;
      i1 <= '0;
      sv <= '0;
      sl <= '0;
      for (int i = 0; i < NS; i++) begin
        sd[i] <= '0;
        sk[i] <= '0;
      end
    end else begin
      if (en1) begin
        v1 <= bus.valid_i;
        if (bus.valid_i) begin
          d1 <= bus.data_in;
          l1 <= bus.last_i;
          k1 <= bus.keep_i;
          i1 <= fold(bus.data_in[KO +: KEY_WIDTH]);
        end
      end
      if (en_s[0]) begin
        sv[0] <= v1;
        if (v1) begin
          sd[0] <= res;
          sl[0] <= l1;
          sk[0] <= k1;
        end
      end
      for (int i = 1; i < NS; i++) begin
        if (en_s[i]) begin
          sv[i] <= sv[i-1];
          if (sv[i-1]) begin
            sd[i] <= sd[i-1];
            sl[i] <= sl[i-1];
            sk[i] <= sk[i-1];
          end
        end
      end
    end
  end

  assign bus.valid_o     = sv[NS-1];
  assign bus.read_data_o = sd[NS-1];
  assign bus.last_o      = sl[NS-1];
  assign bus.keep_o      = sk[NS-1];
  assign fill_count_o    = fill;

`ifdef HASH_TABLE_PIPELINE_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_count_o       <= '0;
      miss_count_o      <= '0;
      collision_count_o <= '0;
    end else if (xfer) begin
      unique case (st)
        ST_HIT:  hit_count_o       <= hit_count_o + 1'b1;
        ST_MISS: miss_count_o      <= miss_count_o + 1'b1;
        ST_COL:  collision_count_o <= collision_count_o + 1'b1;
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_hash_table_pipeline.sv
// Self-checking bench for hash_table_pipeline (OUT_STAGES=2):
// directed literal checks plus randomized traffic against a behavioural table model.
module tb_hash_table_pipeline;

  localparam int OS = 2;

  logic       clk;
  logic       reset;
  logic [4:0] fill;

  hash_table_pipeline_if #(.DATA_WIDTH(32), .KEEP_WIDTH(8)) bus ();

  hash_table_pipeline #(
    .DATA_WIDTH(32), .KEY_WIDTH(12), .VALUE_WIDTH(16),
    .ADDR_WIDTH(4), .KEEP_WIDTH(8), .OUT_STAGES(OS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .fill_count_o(fill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural table: one slot per index, ops applied in accept order.
  bit          mocc [16];
  logic [11:0] mkey [16];
  logic [15:0] mval [16];
  int          mfill = 0;

  function automatic int hidx(input logic [11:0] k);
    return int'(k[3:0] ^ k[7:4] ^ k[11:8]);
  endfunction

  task automatic model_op(input logic [31:0] d, output logic [31:0] r);
    logic [1:0]  op;
    logic [11:0] k;
    logic [15:0] v;
    logic [1:0]  s;
    int          i;
    bit          h;
    op = d[31:30];
    k  = d[27:16];
    v  = d[15:0];
    i  = hidx(k);
    h  = mocc[i] && (mkey[i] == k);
    s  = 2'b00;
    case (op)
      2'b01: if (h) begin s = 2'b01; v = mval[i]; end else s = 2'b10;
      2'b10: begin
        if (!mocc[i]) begin
          mocc[i] = 1'b1; mkey[i] = k; mval[i] = v; mfill++; s = 2'b01;
        end else if (h) begin
          mval[i] = v; s = 2'b01;
        end else s = 2'b11;
      end
      2'b11: if (h) begin mocc[i] = 1'b0; mfill--; s = 2'b01; end
             else s = 2'b10;
      default: s = 2'b00;
    endcase
    r = {s, 2'b00, k, v};
  endtask

  typedef struct {
    logic [31:0] d;
    logic        l;
    logic [7:0]  k;
  } exp_t;

  exp_t        q [$];
  logic [31:0] got [$];
  bit          prev_stall = 0;
  logic [31:0] p_d;
  logic        p_l;
  logic [7:0]  p_k;

  always @(negedge clk) begin
    logic [31:0] r;
    exp_t        e;
    if (!reset) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", bus.valid_o, 1'b1);
        chk("hold_data", bus.read_data_o, p_d);
        chk("hold_last", bus.last_o, p_l);
        chk("hold_keep", bus.keep_o, p_k);
      end
      if (bus.valid_o && bus.ready_i) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out: got %0h expected none",
                   bus.read_data_o);
        end else begin
          e = q.pop_front();
          chk("out_data", bus.read_data_o, e.d);
          chk("out_last", bus.last_o, e.l);
          chk("out_keep", bus.keep_o, e.k);
        end
        got.push_back(bus.read_data_o);
      end
      prev_stall = bus.valid_o && !bus.ready_i;
      p_d = bus.read_data_o;
      p_l = bus.last_o;
      p_k = bus.keep_o;
      if (bus.valid_i && bus.ready_o) begin
        model_op(bus.data_in, r);
        q.push_back('{r, bus.last_i, bus.keep_i});
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic l,
                      input logic [7:0] k);
    int n;
    n = 0;
    bus.valid_i = 1'b1;
    bus.data_in = d;
    bus.last_i  = l;
    bus.keep_i  = k;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.ready_o && n < 200);
    if (n >= 200) chk("send_timeout", n, 0);
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
  endtask

  task automatic run_op(input logic [31:0] d, output logic [31:0] r,
                        output int lat);
    send(d, 1'b1, 8'hFF);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.valid_o && lat < 50);
    r = bus.read_data_o;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_empty", q.size(), 0);
  endtask

  logic [31:0] r;
  int          lat;
  logic [31:0] sb [5];
  int          bi;
  int          acc;
  logic        last_rdy;
  logic [11:0] pool [8];

  initial begin
    pool = '{12'h012, 12'h102, 12'h021, 12'h034,
             12'h055, 12'h300, 12'h0F0, 12'hABC};
    reset       = 1'b0;
    bus.valid_i = 1'b0;
    bus.data_in = '0;
    bus.last_i  = 1'b0;
    bus.keep_i  = '0;
    bus.ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", bus.valid_o, 1'b0);
    chk("rst_fill", fill, 0);
    chk("rst_data", bus.read_data_o, 0);
    chk("rst_last", bus.last_o, 1'b0);
    chk("rst_keep", bus.keep_o, 0);
    chk("rst_ready", bus.ready_o, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    run_op(32'h8012_BEEF, r, lat);
    chk("write_latency", lat, 2 + OS);
    chk("write_status", r, 32'h4012_BEEF);
    chk("write_fill", fill, 1);
    run_op(32'h4012_0000, r, lat);
    chk("read_hit", r, 32'h4012_BEEF);

    run_op(32'h8102_1234, r, lat);
    chk("collision", r, 32'hC102_1234);
    chk("collision_fill", fill, 1);
    run_op(32'h4012_0000, r, lat);
    chk("read_after_col", r, 32'h4012_BEEF);

    run_op(32'hC012_0000, r, lat);
    chk("delete_hit", r, 32'h4012_0000);
    chk("delete_fill", fill, 0);
    run_op(32'hC012_0000, r, lat);
    chk("delete_miss", r, 32'h8012_0000);
    run_op(32'h4012_5555, r, lat);
    chk("read_miss", r, 32'h8012_5555);

    got.delete();
    send(32'h8034_1111, 1'b0, 8'h0F);
    send(32'h4034_0000, 1'b1, 8'hF0);
    drain();
    chk("b2b_count", got.size(), 2);
    if (got.size() == 2) begin
      chk("b2b_write", got[0], 32'h4034_1111);
      chk("b2b_read", got[1], 32'h4034_1111);
    end

    sb = '{32'h80A1_0001, 32'h80A2_0002, 32'h40A1_0000,
           32'h40A2_0000, 32'h40B3_0777};
    got.delete();
    bus.ready_i = 1'b0;
    bi  = 0;
    acc = 0;
    last_rdy = 1'b1;
    for (int c = 0; c < 5; c++) begin
      bus.valid_i = 1'b1;
      bus.data_in = sb[bi];
      bus.last_i  = bi[0];
      bus.keep_i  = 8'(bi + 1);
      @(negedge clk);
      if (bus.ready_o) begin
        bi++;
        acc++;
      end
      last_rdy = bus.ready_o;
      @(posedge clk);
      #1;
    end
    chk("stall_accepts", acc, 4);
    chk("stall_ready_low", last_rdy, 1'b0);
    bus.ready_i = 1'b1;
    for (int c = 0; c < 20 && bi < 5; c++) begin
      bus.valid_i = 1'b1;
      bus.data_in = sb[bi];
      bus.last_i  = bi[0];
      bus.keep_i  = 8'(bi + 1);
      @(negedge clk);
      if (bus.ready_o) bi++;
      @(posedge clk);
      #1;
    end
    bus.valid_i = 1'b0;
    drain();
    chk("stall_count", got.size(), 5);
    if (got.size() == 5) begin
      chk("stall_read_a2", got[3], 32'h40A2_0002);
      chk("stall_miss_b3", got[4], 32'h80B3_0777);
    end

    for (int c = 0; c < 3000; c++) begin
      bus.valid_i = ($urandom % 4) != 0;
      bus.data_in = {2'($urandom), 2'($urandom),
                     pool[$urandom % 8], 16'($urandom)};
      bus.last_i  = 1'($urandom);
      bus.keep_i  = 8'($urandom);
      bus.ready_i = ($urandom % 10) < 7;
      @(posedge clk);
      #1;
    end
    drain();
    chk("random_fill", fill, mfill);

    send(32'h8055_ABCD, 1'b1, 8'h01);
    drain();
    chk("pre_reset_fill", fill, mfill);
    bus.ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      bus.valid_i = 1'b1;
      bus.data_in = 32'h4055_0000 | 32'(c);
      @(posedge clk);
      #1;
    end
    bus.valid_i = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 16; i++) mocc[i] = 1'b0;
    mfill = 0;
    q.delete();
    #1;
    chk("midrst_valid", bus.valid_o, 1'b0);
    chk("midrst_fill", fill, 0);
    chk("midrst_data", bus.read_data_o, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.ready_i = 1'b1;
    @(posedge clk);
    #1;
    run_op(32'h4055_0077, r, lat);
    chk("post_reset_read", r, 32'h8055_0077);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/hash_table_pipeline.md
# hash_table_pipeline

Parametrised successor to the minimal hash-table pipeline: a stream-in/stream-out block that actually stores key/value pairs in a direct-mapped table. It decodes read/write/delete/nop from the top two bits of each accepted beat and returns a status-tagged result beat with `last`/`keep` aligned. Latency is configurable, and there is real valid/ready backpressure. It sits between the stream ingress and egress stages of the hash-table datapath.

## Interface
- `DATA_WIDTH`, 32: beat width; must be ≥ `KEY_WIDTH+VALUE_WIDTH+2`.
- `KEY_WIDTH`, 12: key field, `data_in[VALUE_WIDTH +: KEY_WIDTH]`.
- `VALUE_WIDTH`, 16: value field, `data_in[VALUE_WIDTH-1:0]`.
- `ADDR_WIDTH`, 4: table has 2^ADDR_WIDTH entries; must be ≤ `KEY_WIDTH`.
- `KEEP_WIDTH`, 8: width of keep sideband.
- `OUT_STAGES`, 0: extra output register stages (0..8).

Ports:
- `clk`, in, 1: single clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `data_in`, in, DATA_WIDTH: op `[DATA_WIDTH-1 -: 2]` (00 nop, 01 read, 10 write, 11 delete), key, value.
- `valid_i`, in, 1: input beat valid.
- `ready_o`, out, 1: block accepts the beat this cycle.
- `last_i`, in, 1: packet end; passed through.
- `keep_i`, in, KEEP_WIDTH: byte keep; passed through.
- `ready_i`, in, 1: downstream ready.
- `valid_o`, out, 1: result beat valid.
- `read_data_o`, out, DATA_WIDTH: status `[DATA_WIDTH-1 -: 2]`, key, value; the remaining middle bits are zero.
- `last_o`, out, 1: aligned last.
- `keep_o`, out, KEEP_WIDTH: aligned keep.
- `fill_count_o`, out, ADDR_WIDTH+1: number of occupied entries.

## Operation
- Hash index: XOR-fold of the key in ADDR_WIDTH-bit slices. The top slice is zero-padded.
- Entry contents: occupied flag, full key, value.
- Stage 1 (S1) registers the beat and computes the index. Stage 2 (S2) reads the entry and, on transfer, updates it. Stages S3..S(2+OUT_STAGES) are plain registers.
- Status codes: 00 = nop, 01 = success/hit, 10 = miss, 11 = collision.
- read:
  - Occupied and key equal: status 01, value = stored value.
  - Otherwise: status 10, value = input value.
- write:
  - Slot empty: insert, status 01, fill +1.
  - Same key: overwrite value, status 01, fill unchanged.
  - Different key: no change, status 11.
- delete:
  - Occupied and key equal: clear the occupied flag, status 01, fill −1.
  - Otherwise: status 10.
- nop: beat passes with status 00 and unchanged key/value. The table is untouched.
- Output key field always echoes the input key.
- The table is modified only in the cycle its S2 beat advances. Back-to-back ops on the same index see the prior op's result; there is no hazard.
- `last`/`keep` travel in lockstep with their beat.

## Timing
- Reset (async assert, sync deassert by upstream):
  - All stage valids 0, so `valid_o`=0.
  - All occupied flags 0; `fill_count_o`=0.
  - `read_data_o`, `last_o`, `keep_o` = 0.
- Advance enable per stage: `en_k = !v_k || en_(k+1)`; the output stage uses `en = !valid_o || ready_i`.
- `ready_o = en_1`. This is combinational from `ready_i` and the stage valids, so bubbles collapse.
- Accept when `valid_i && ready_o`. The accepted beat appears at `valid_o` after 2+OUT_STAGES cycles with no stalls.
- Full throughput of 1 beat/cycle while `ready_i`=1.
- While `valid_o && !ready_i`:
  - Output holds stable.
  - Upstream stages keep filling bubbles until full.
  - `ready_o` drops once all stages are valid.
  - The S2 table update is held until S2 advances.
- `fill_count_o` updates the cycle after the S2 transfer. It saturates to neither limit; it can only reach 2^ADDR_WIDTH or 0 legitimately.
- Reset mid-operation: in-flight beats are discarded and the table is emptied.

## Configuration
- Macro `HASH_TABLE_PIPELINE_STATS_EN`.
- When defined, the block adds three outputs: `hit_count_o`, `miss_count_o`, `collision_count_o`, each 32 bits. Each increments on S2 transfer with the matching status, wraps at 2^32, and resets to 0.
- When undefined, the ports and counters are absent. All other behaviour is identical.

## Test plan
- Reset, then write key 0x012/value 0xBEEF with `ready_i`=1. Expect status 01 on `valid_o` exactly 2 cycles after accept and `fill_count_o`=1. A following read of 0x012 returns 0xBEEF with status 01.
- Write 0x012, then write 0x102. Both hash to the same index for ADDR_WIDTH=4, key 12-bit. The second returns status 11, the table is unchanged, and fill stays 1.
- Delete 0x012 returns status 01 and fill 0. A second delete returns status 10, and a read of 0x012 returns status 10 with the input value echoed.
- Back-to-back write 0x034=0x1111 then read 0x034 on consecutive cycles: the read returns 0x1111.
- Hold `ready_i`=0 for 5 cycles while streaming 4 beats, OUT_STAGES=2. `ready_o` falls after 4 accepts, and the outputs emerge in order with correct `last`/`keep` and no loss or duplication.
- Assert `reset` mid-stream with 3 beats in flight: `valid_o`=0 immediately, fill=0, and a post-reset read of a previously written key returns status 10.
